// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus responder: I/O register offsets, control bits,
// vector addresses and the address-region decode type.
package cpu_bus_pkg;

    localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
    localparam logic [3:0] OFF_RELOAD_L = 4'd2;
    localparam logic [3:0] OFF_RELOAD_H = 4'd3;
    localparam logic [3:0] OFF_COUNT_L  = 4'd4;
    localparam logic [3:0] OFF_COUNT_H  = 4'd5;
    localparam logic [3:0] OFF_CTRL     = 4'd6;
    localparam logic [3:0] OFF_STATUS   = 4'd7;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_LOAD_BIT   = 2;
    localparam int STATUS_FLAG_BIT = 0;

    localparam logic [15:0] VEC_NMI_L   = 16'hFFFA;
    localparam logic [15:0] VEC_NMI_H   = 16'hFFFB;
    localparam logic [15:0] VEC_RESET_L = 16'hFFFC;
    localparam logic [15:0] VEC_RESET_H = 16'hFFFD;
    localparam logic [15:0] VEC_IRQ_L   = 16'hFFFE;
    localparam logic [15:0] VEC_IRQ_H   = 16'hFFFF;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_IO,
        REGION_VEC,
        REGION_NONE
    } region_e;

    // The reset pair returns the reset vector; the NMI and IRQ pairs both return the IRQ vector.
    function automatic logic [7:0] vector_byte(input logic [15:0] address,
                                               input logic [15:0] reset_vector,
                                               input logic [15:0] irq_vector);
        logic [15:0] vec;
        vec = (address[15:1] == VEC_RESET_L[15:1]) ? reset_vector : irq_vector;
        return address[0] ? vec[15:8] : vec[7:0];
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Interval timer for the bus responder I/O page: prescaler, 16-bit down-counter with
// reload, underflow flag and registered interrupt request.
module bus_timer
    import cpu_bus_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [3:0] offset,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler;
    logic [15:0]   count;
    logic [15:0]   reload;
    logic [7:0]    shadow;
    logic          enable;
    logic          irq_en;
    logic          flag;

    logic load;
    logic tick;
    logic underflow;
    logic status_rd;
    logic count_l_rd;

    always_comb begin
        load       = wr_en && (offset == OFF_CTRL) && wdata[CTRL_LOAD_BIT];
        tick       = enable && (prescaler == PRE_MAX);
        // A coincident load takes the counter, so it cannot also underflow.
        underflow  = tick && !load && (count == 16'd0);
        status_rd  = rd_en && (offset == OFF_STATUS);
        count_l_rd = rd_en && (offset == OFF_COUNT_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            count     <= 16'd0;
            reload    <= 16'd0;
            shadow    <= 8'd0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            flag      <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (load) begin
                prescaler <= '0;
            end else if (enable) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
            end

            if (load) begin
                count <= reload;
            end else if (tick) begin
                count <= (count == 16'd0) ? reload : count - 16'd1;
            end

            if (wr_en && offset == OFF_RELOAD_L) reload[7:0]  <= wdata;
            if (wr_en && offset == OFF_RELOAD_H) reload[15:8] <= wdata;

            if (wr_en && offset == OFF_CTRL) begin
                enable <= wdata[CTRL_ENABLE_BIT];
                irq_en <= wdata[CTRL_IRQ_EN_BIT];
            end

            // Set beats read-clear when both land on the same edge.
            if (underflow) begin
                flag <= 1'b1;
            end else if (status_rd) begin
                flag <= 1'b0;
            end

            if (count_l_rd) shadow <= count[15:8];

            irq <= flag & irq_en;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (offset)
            OFF_RELOAD_L: rdata = reload[7:0];
            OFF_RELOAD_H: rdata = reload[15:8];
            OFF_COUNT_L:  rdata = count[7:0];
            OFF_COUNT_H:  rdata = shadow;
            OFF_CTRL:     rdata = {6'd0, irq_en, enable};
            OFF_STATUS:   rdata = {7'd0, flag};
            default:      rdata = 8'h00;
        endcase
    end

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the 8-bit CPU bus: RAM, GPIO/timer I/O page and vector bytes.
// Timer and IRQ exist only when BUS_RESPONDER_TIMER_EN is defined.
module bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int          RAM_AW        = 12,
    parameter logic [15:0] IO_BASE       = 16'hFE00,
    parameter int          PRESCALE      = 16,
    parameter logic [15:0] RESET_VECTOR  = 16'h0200,
    parameter logic [15:0] IRQ_VECTOR    = 16'h0300,
    parameter logic [7:0]  UNMAPPED_DATA = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        irq
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    region_e           region;
    logic [3:0]        offset;
    logic [RAM_AW-1:0] ram_addr;
    logic              io_wr;
    logic              io_rd;
    logic [7:0]        gpio_sync1;
    logic [7:0]        gpio_sync2;
    logic [7:0]        timer_rdata;
    logic [7:0]        io_rdata;
    logic [7:0]        rd_mux;
    logic [7:0]        ram [RAM_DEPTH];

    always_comb begin
        region = REGION_NONE;
        if ((address >> RAM_AW) == 16'd0) begin
            region = REGION_RAM;
        end else if (address[15:4] == IO_BASE[15:4]) begin
            region = REGION_IO;
        end else if (address >= VEC_NMI_L) begin
            region = REGION_VEC;
        end
    end

    assign offset   = address[3:0];
    assign ram_addr = address[RAM_AW-1:0];
    assign io_wr    = (region == REGION_IO) && !read_write;
    assign io_rd    = (region == REGION_IO) && read_write;

    // RAM is not reset; writes are suppressed while rst is asserted.
    always_ff @(posedge clk) begin
        if (!rst && region == REGION_RAM && !read_write) begin
            ram[ram_addr] <= data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_sync1 <= 8'h00;
            gpio_sync2 <= 8'h00;
            gpio_out   <= 8'h00;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            if (io_wr && offset == OFF_GPIO_OUT) gpio_out <= data_write;
        end
    end

`ifdef BUS_RESPONDER_TIMER_EN
    bus_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (io_wr),
        .rd_en  (io_rd),
        .offset (offset),
        .wdata  (data_write),
        .rdata  (timer_rdata),
        .irq    (irq)
    );
`else
    assign timer_rdata = 8'h00;
    assign irq         = 1'b0;
`endif

    // Offsets 2-15 all come from the timer block, which returns 0 for anything it does not own.
    always_comb begin
        io_rdata = timer_rdata;
        case (offset)
            OFF_GPIO_OUT: io_rdata = gpio_out;
            OFF_GPIO_IN:  io_rdata = gpio_sync2;
            default:      io_rdata = timer_rdata;
        endcase
    end

    always_comb begin
        rd_mux = UNMAPPED_DATA;
        case (region)
            REGION_RAM: rd_mux = ram[ram_addr];
            REGION_IO:  rd_mux = io_rdata;
            REGION_VEC: rd_mux = vector_byte(address, RESET_VECTOR, IRQ_VECTOR);
            default:    rd_mux = UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_read <= UNMAPPED_DATA;
        end else if (read_write) begin
            data_read <= rd_mux;
        end
    end

    // Unused in builds without the timer.
    logic unused_io_rd;
    assign unused_io_rd = io_rd;

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder: table of bus vectors plus
// hand-written GPIO synchroniser, timer and reset sequences.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic        read_write;
    logic [7:0]  data_write;
    logic [7:0]  data_read;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    bus_responder #(
        .RAM_AW        (12),
        .IO_BASE       (16'hFE00),
        .PRESCALE      (16),
        .RESET_VECTOR  (16'h0200),
        .IRQ_VECTOR    (16'h0300),
        .UNMAPPED_DATA (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .read_write (read_write),
        .data_write (data_write),
        .data_read  (data_read),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs[21];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, sample 1ns after the rising edge.
    task automatic bus_op(input logic [15:0] a, input logic rw, input logic [7:0] wd);
        @(negedge clk);
        address    = a;
        read_write = rw;
        data_write = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus_op(16'h8000, 1'b1, 8'h00);
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        bus_op(a, 1'b1, 8'h00);
        check8(name, data_read, exp);
    endtask

    initial begin
        rst        = 1'b1;
        address    = 16'h8000;
        read_write = 1'b1;
        data_write = 8'h00;
        gpio_in    = 8'h00;

        vecs[0]  = '{16'h0124, 1'b0, 8'h5A, 8'h00, 8'h00};
        vecs[1]  = '{16'h0123, 1'b0, 8'hA5, 8'h00, 8'h00};
        vecs[2]  = '{16'h0123, 1'b1, 8'h00, 8'hA5, 8'h00};
        vecs[3]  = '{16'h0124, 1'b1, 8'h00, 8'h5A, 8'h00};
        vecs[4]  = '{16'h0FFF, 1'b0, 8'h11, 8'h5A, 8'h00};
        vecs[5]  = '{16'h0FFF, 1'b1, 8'h00, 8'h11, 8'h00};
        vecs[6]  = '{16'h1123, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{16'hFFFC, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{16'hFFFD, 1'b1, 8'h00, 8'h02, 8'h00};
        vecs[9]  = '{16'hFFFC, 1'b0, 8'h77, 8'h02, 8'h00};
        vecs[10] = '{16'hFFFC, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{16'hFFFE, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[12] = '{16'hFFFF, 1'b1, 8'h00, 8'h03, 8'h00};
        vecs[13] = '{16'hFFFA, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[14] = '{16'hFFFB, 1'b1, 8'h00, 8'h03, 8'h00};
        vecs[15] = '{16'hFE00, 1'b0, 8'h3C, 8'h03, 8'h3C};
        vecs[16] = '{16'hFE00, 1'b1, 8'h00, 8'h3C, 8'h3C};
        vecs[17] = '{16'hFE08, 1'b1, 8'h00, 8'h00, 8'h3C};
        vecs[18] = '{16'h8000, 1'b0, 8'h55, 8'h00, 8'h3C};
        vecs[19] = '{16'h8000, 1'b1, 8'h00, 8'h00, 8'h3C};
        vecs[20] = '{16'hFE0F, 1'b1, 8'h00, 8'h00, 8'h3C};

        repeat (2) @(posedge clk);
        #1;
        check8("reset data_read", data_read, 8'h00);
        check8("reset gpio_out", gpio_out, 8'h00);
        check8("reset irq", {7'd0, irq}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            bus_op(vecs[i].addr, vecs[i].rw, vecs[i].wd);
            check8($sformatf("vec%0d data_read", i), data_read, vecs[i].exp_rd);
            check8($sformatf("vec%0d gpio_out", i), gpio_out, vecs[i].exp_gpio);
        end

        // Two synchroniser flops: value visible to a read on the third edge after it is applied.
        gpio_in = 8'h81;
        idle(1);
        rd_chk("gpio_in sync early", 16'hFE01, 8'h00);
        rd_chk("gpio_in sync", 16'hFE01, 8'h81);

`ifdef BUS_RESPONDER_TIMER_EN
        bus_op(16'hFE02, 1'b0, 8'h02);
        bus_op(16'hFE03, 1'b0, 8'h00);
        rd_chk("reload_l readback", 16'hFE02, 8'h02);
        rd_chk("reload_h readback", 16'hFE03, 8'h00);
        bus_op(16'hFE06, 1'b0, 8'h07);                      // edge E: enable, irq_en, load
        rd_chk("ctrl readback", 16'hFE06, 8'h03);           // E+1
        rd_chk("count after load", 16'hFE04, 8'h02);        // E+2
        rd_chk("count_h shadow", 16'hFE05, 8'h00);          // E+3
        idle(13);
        rd_chk("count tick1", 16'hFE04, 8'h01);             // E+17
        idle(15);
        rd_chk("count tick2", 16'hFE04, 8'h00);             // E+33
        idle(15);                                           // E+48 underflow
        check8("irq same edge as flag", {7'd0, irq}, 8'h00);
        idle(1);
        check8("irq after underflow", {7'd0, irq}, 8'h01);
        rd_chk("count reloaded", 16'hFE04, 8'h02);          // E+50
        rd_chk("status set", 16'hFE07, 8'h01);              // E+51
        check8("irq while clearing", {7'd0, irq}, 8'h01);
        rd_chk("status cleared", 16'hFE07, 8'h00);          // E+52
        check8("irq deasserted", {7'd0, irq}, 8'h00);
        idle(43);
        rd_chk("status on underflow edge", 16'hFE07, 8'h00); // E+96
        idle(1);
        check8("irq after racing read", {7'd0, irq}, 8'h01);
        idle(1);
        check8("irq held", {7'd0, irq}, 8'h01);
        bus_op(16'hFE02, 1'b0, 8'h05);
        rd_chk("reload write keeps count", 16'hFE04, 8'h02);
`else
        bus_op(16'hFE02, 1'b0, 8'hAA);
        bus_op(16'hFE06, 1'b0, 8'h07);
        for (int off = 2; off < 8; off++) begin
            rd_chk($sformatf("no-timer offset %0d", off), 16'hFE00 + 16'(off), 8'h00);
        end
        idle(40);
        check8("no-timer irq", {7'd0, irq}, 8'h00);
`endif

        bus_op(16'hFE00, 1'b0, 8'hFF);
        check8("gpio_out before rst", gpio_out, 8'hFF);
        rd_chk("read before rst", 16'hFFFD, 8'h02);
        @(negedge clk);
        rst        = 1'b1;
        address    = 16'hFE00;
        read_write = 1'b0;
        data_write = 8'h55;
        @(posedge clk);
        #1;
        check8("rst gpio_out", gpio_out, 8'h00);
        check8("rst irq", {7'd0, irq}, 8'h00);
        check8("rst data_read", data_read, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst count_l", 16'hFE04, 8'h00);
        rd_chk("rst count_h", 16'hFE05, 8'h00);
        rd_chk("rst status", 16'hFE07, 8'h00);
        rd_chk("ram kept across rst", 16'h0123, 8'hA5);
        check8("irq after rst", {7'd0, irq}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
